// File: rtl/audio_serdes_sync.sv
// Audio codec serial interface, single system-clock domain.
// Oversamples BCK/LRCK/ADCDAT and deserialises ADC words into left/right
// registers. Serialises DAC words onto AUD_DATA from a shadow pair that is
// latched once per frame, at the start of the left half.
module audio_serdes_sync #(
  parameter int DATA_W   = 16,  // sample width, 8..32
  parameter int I2S_MODE = 0,   // 1: MSB one BCK after the LRCK edge
  parameter int LEFT_LVL = 1,   // LRCK level meaning "left"
  parameter int SYNC     = 2    // synchroniser depth, >= 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              AUD_BCK,
  input  logic              AUD_LRCK,
  input  logic              AUD_ADCDAT,
  output logic              AUD_DATA,
  input  logic [DATA_W-1:0] iAUD_outL,
  input  logic [DATA_W-1:0] iAUD_outR,
  output logic [DATA_W-1:0] oAUD_inL,
  output logic [DATA_W-1:0] oAUD_inR,
  output logic              oIN_VALID,
  output logic              oIN_RIGHT,
  output logic              oOUT_STB
);

  localparam int                CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]     CNT_FULL  = CW'(DATA_W);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MSB_ONE   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic              LEFT_BIT  = (LEFT_LVL != 0);
  localparam logic              SKIP_INIT = (I2S_MODE != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC-1:0]   bck_sr, lr_sr, dat_sr;
  logic              bck_d, lr_d;
  logic              bck_s, lr_s, dat_s;
  logic              bck_rise, bck_fall, lr_chg, half_start;
  state_t            state, state_nxt;

  logic              chan_right;   // channel of the half in progress
  logic [CW-1:0]     bit_cnt;      // bits handled in this half, saturates
  logic              skip;         // swallows the first BCK period in I2S
  logic              committed;    // this half already produced its word
  logic [DATA_W-1:0] sh_in;        // ADC word under assembly
  logic [DATA_W-1:0] sh_l, sh_r;   // DAC shadow pair

  logic              new_right, cnt_live, tx_bit, start_bit;
  logic [DATA_W-1:0] bit_mask, sh_in_nxt, tx_word, start_word, commit_word;
  logic              commit_lr, commit_bit;

  // Pin synchronisers plus one-cycle-delayed copies for edge detection
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bck_sr <= '0;
      lr_sr  <= '0;
      dat_sr <= '0;
      bck_d  <= 1'b0;
      lr_d   <= 1'b0;
    end else begin
      bck_sr <= {bck_sr[SYNC-2:0], AUD_BCK};
      lr_sr  <= {lr_sr[SYNC-2:0], AUD_LRCK};
      dat_sr <= {dat_sr[SYNC-2:0], AUD_ADCDAT};
      bck_d  <= bck_sr[SYNC-1];
      lr_d   <= lr_sr[SYNC-1];
    end
  end

  assign bck_s      = bck_sr[SYNC-1];
  assign lr_s       = lr_sr[SYNC-1];
  assign dat_s      = dat_sr[SYNC-1];
  assign bck_rise   = bck_s & ~bck_d;
  assign bck_fall   = ~bck_s & bck_d;
  assign lr_chg     = lr_s ^ lr_d;
  // LRCK moves on BCK falling edges, so a half starts on a coincident pair
  assign half_start = bck_fall & lr_chg;

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: leave IDLE on the first LRCK edge, then run until reset
  always_comb begin
    state_nxt = state;
    if (state == IDLE && half_start) state_nxt = ACTIVE;
  end

  // Bit-level helpers: one-hot cursor into the word, next ADC word, DAC bit
  always_comb begin
    new_right   = (lr_s != LEFT_BIT);
    cnt_live    = (bit_cnt < CNT_FULL);
    bit_mask    = MSB_ONE >> bit_cnt;
    sh_in_nxt   = dat_s ? (sh_in | bit_mask) : (sh_in & ~bit_mask);
    tx_word     = chan_right ? sh_r : sh_l;
    tx_bit      = cnt_live & (|(tx_word & bit_mask));
    // a new left half drives straight from the input, shadow loads same cycle
    start_word  = new_right ? sh_r : iAUD_outL;
    start_bit   = start_word[DATA_W-1];
    commit_lr   = half_start && (state == ACTIVE) && !committed;
    commit_bit  = !half_start && (state == ACTIVE) && bck_rise && !skip &&
                  (bit_cnt == CNT_LAST);
    commit_word = commit_lr ? sh_in : sh_in_nxt;
  end

  // Half-frame sequencing, ADC shifting, DAC drive and shadow latch
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      chan_right <= 1'b0;
      bit_cnt    <= '0;
      skip       <= 1'b0;
      committed  <= 1'b0;
      sh_in      <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      AUD_DATA   <= 1'b0;
      oOUT_STB   <= 1'b0;
    end else begin
      oOUT_STB <= 1'b0;
      if (half_start) begin
        chan_right <= new_right;
        bit_cnt    <= '0;
        skip       <= SKIP_INIT;
        committed  <= 1'b0;
        sh_in      <= '0;  // short halves commit with zero LSBs
        AUD_DATA   <= SKIP_INIT ? 1'b0 : start_bit;
        if (!new_right) begin
          sh_l     <= iAUD_outL;
          sh_r     <= iAUD_outR;
          oOUT_STB <= 1'b1;
        end
      end else if (state == ACTIVE) begin
        if (bck_fall) AUD_DATA <= skip ? 1'b0 : tx_bit;
        if (bck_rise) begin
          if (skip) begin
            skip <= 1'b0;
          end else if (cnt_live) begin
            sh_in   <= sh_in_nxt;
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        if (commit_bit) committed <= 1'b1;
      end
    end
  end

  // Committed ADC words and the valid/channel flags toward the datapath
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oAUD_inL  <= '0;
      oAUD_inR  <= '0;
      oIN_VALID <= 1'b0;
      oIN_RIGHT <= 1'b0;
    end else begin
      oIN_VALID <= commit_lr | commit_bit;
      if (commit_lr | commit_bit) begin
        oIN_RIGHT <= chan_right;
        if (chan_right) oAUD_inR <= commit_word;
        else            oAUD_inL <= commit_word;
      end
    end
  end

endmodule

// File: tb/tb_audio_serdes_sync.sv
// Bench for audio_serdes_sync: two instances share the codec pins.
// A: 16-bit left-justified, LRCK high = left. B: 24-bit I2S, LRCK low = left.
// A per-half model computes expected ADC words and DAC bit streams.
module tb_audio_serdes_sync;
  localparam int WA = 16;
  localparam int WB = 24;

  typedef struct packed { logic right; logic [31:0] data; } cm_t;

  logic iCLK = 1'b0, iRST = 1'b1, bck = 1'b0, lrck = 1'b0, adc = 1'b0;
  logic [31:0] out_l = '0, out_r = '0;
  logic dac_a, dac_b, vld_a, vld_b, rgt_a, rgt_b, stb_a, stb_b;
  logic [WA-1:0] inl_a, inr_a;
  logic [WB-1:0] inl_b, inr_b;

  audio_serdes_sync #(.DATA_W(WA), .I2S_MODE(0), .LEFT_LVL(1), .SYNC(2)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .AUD_BCK(bck), .AUD_LRCK(lrck), .AUD_ADCDAT(adc),
    .AUD_DATA(dac_a), .iAUD_outL(out_l[WA-1:0]), .iAUD_outR(out_r[WA-1:0]),
    .oAUD_inL(inl_a), .oAUD_inR(inr_a), .oIN_VALID(vld_a), .oIN_RIGHT(rgt_a),
    .oOUT_STB(stb_a));

  audio_serdes_sync #(.DATA_W(WB), .I2S_MODE(1), .LEFT_LVL(0), .SYNC(2)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .AUD_BCK(bck), .AUD_LRCK(lrck), .AUD_ADCDAT(adc),
    .AUD_DATA(dac_b), .iAUD_outL(out_l[WB-1:0]), .iAUD_outR(out_r[WB-1:0]),
    .oAUD_inL(inl_b), .oAUD_inR(inr_b), .oIN_VALID(vld_b), .oIN_RIGHT(rgt_b),
    .oOUT_STB(stb_b));

  always #5 iCLK = ~iCLK;

  cm_t qa[$], qb[$];
  bit  dq_a[$], dq_b[$];
  int  n_cmp = 0, n_err = 0;
  int  stb_exp[2], stb_got[2];
  bit  active[2], pend[2], cur_r[2];
  logic [31:0] pend_w[2], shl[2], shr[2];

  function automatic int wd(input int i);  return (i == 0) ? WA : WB; endfunction
  function automatic int off(input int i); return (i == 0) ? 0 : 1;   endfunction
  function automatic int ll(input int i);  return (i == 0) ? 1 : 0;   endfunction
  function automatic logic [31:0] msk(input int i);
    return (32'd1 << wd(i)) - 32'd1;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got an event, expected none at %0t", nm, $time);
  endtask

  task automatic push(input int i, input bit r, input logic [31:0] d);
    cm_t e;
    e.right = r;
    e.data  = d;
    if (i == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Expected DAC bit in slot j of the current half
  function automatic bit dac_exp(input int i, input int j);
    int k;
    logic [31:0] w;
    if (!active[i]) return 1'b0;
    k = j - off(i);
    if (k < 0 || k >= wd(i)) return 1'b0;
    w = cur_r[i] ? shr[i] : shl[i];
    return w[wd(i)-1-k];
  endfunction

  // New half of S slots: close out the previous short half, latch the
  // shadow pair on a left start, and work out this half's ADC word.
  task automatic model_start(input int i, input bit newlr, input int s,
                             input logic [31:0] bits, input int rst_slot);
    int n;
    logic [31:0] w;
    bit killed;
    if (active[i] && pend[i]) push(i, cur_r[i], pend_w[i]);
    pend[i]   = 1'b0;
    active[i] = 1'b1;
    cur_r[i]  = (int'(newlr) != ll(i));
    if (!cur_r[i]) begin
      shl[i] = out_l & msk(i);
      shr[i] = out_r & msk(i);
      stb_exp[i]++;
    end
    n = s - off(i);
    if (n > wd(i)) n = wd(i);
    w = '0;
    for (int k = 0; k < n; k++) w[wd(i)-1-k] = bits[31-(k+off(i))];
    killed = (rst_slot >= 0) && (rst_slot < off(i) + wd(i));
    if (!killed) begin
      if (n == wd(i)) push(i, cur_r[i], w);
      else begin
        pend[i]   = 1'b1;
        pend_w[i] = w;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0;
      pend[i]   = 1'b0;
      shl[i]    = '0;
      shr[i]    = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_dac_a"}, 32'(dac_a), 32'd0);
    check({tag, "_dac_b"}, 32'(dac_b), 32'd0);
    check({tag, "_inl_a"}, 32'(inl_a), 32'd0);
    check({tag, "_inr_a"}, 32'(inr_a), 32'd0);
    check({tag, "_inl_b"}, 32'(inl_b), 32'd0);
    check({tag, "_inr_b"}, 32'(inr_b), 32'd0);
    check({tag, "_flags_a"}, {29'd0, vld_a, rgt_a, stb_a}, 32'd0);
    check({tag, "_flags_b"}, {29'd0, vld_b, rgt_b, stb_b}, 32'd0);
  endtask

  // One BCK period: falling edge (data/LRCK change), low, rising edge, high
  task automatic bck_slot(input bit d, input bit flip, input bit ea, input bit eb,
                          input bit do_rst);
    bck = 1'b0;
    adc = d;
    if (flip) lrck = ~lrck;
    dq_a.push_back(ea);
    dq_b.push_back(eb);
    if (do_rst) begin
      repeat (4) @(negedge iCLK);
      iRST = 1'b1;
      @(negedge iCLK);
      chk_zero("midrst");
      iRST = 1'b0;
      repeat (3) @(negedge iCLK);
    end else begin
      repeat (8) @(negedge iCLK);
    end
    bck = 1'b1;
    repeat (8) @(negedge iCLK);
  endtask

  // chg: 0 keep DAC inputs, 1 change them mid-half, 2 maybe change them
  task automatic half(input int s, input logic [31:0] bits, input int rst_slot,
                      input int chg);
    bit newlr;
    newlr = ~lrck;
    model_start(0, newlr, s, bits, rst_slot);
    model_start(1, newlr, s, bits, rst_slot);
    for (int j = 0; j < s; j++) begin
      if (j == rst_slot) model_reset();
      bck_slot(bits[31-j], (j == 0), dac_exp(0, j), dac_exp(1, j), (j == rst_slot));
      if (j == s / 2 && (chg == 1 || (chg == 2 && $urandom_range(1, 0) == 1))) begin
        out_l = $urandom;
        out_r = $urandom;
      end
    end
  endtask

  // Commit scoreboard and OUT_STB counter
  always @(negedge iCLK) begin
    cm_t e;
    if (vld_a) begin
      if (qa.size() == 0) flag("a_commit_unexpected");
      else begin
        e = qa.pop_front();
        check("a_in_right", 32'(rgt_a), 32'(e.right));
        check("a_in_data", e.right ? 32'(inr_a) : 32'(inl_a), e.data);
      end
    end
    if (vld_b) begin
      if (qb.size() == 0) flag("b_commit_unexpected");
      else begin
        e = qb.pop_front();
        check("b_in_right", 32'(rgt_b), 32'(e.right));
        check("b_in_data", e.right ? 32'(inr_b) : 32'(inl_b), e.data);
      end
    end
    if (stb_a) stb_got[0]++;
    if (stb_b) stb_got[1]++;
  end

  // DAC line sampled like the codec does, on BCK rising edges
  always @(posedge bck) begin
    if (dq_a.size() == 0) flag("a_dac_unexpected_slot");
    else check("a_dac", 32'(dac_a), 32'(dq_a.pop_front()));
    if (dq_b.size() == 0) flag("b_dac_unexpected_slot");
    else check("b_dac", 32'(dac_b), 32'(dq_b.pop_front()));
  end

  initial begin
    int opts[6] = '{32, 32, 12, 20, 26, 17};
    model_reset();
    stb_exp = '{0, 0};
    stb_got = '{0, 0};
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    chk_zero("reset");
    iRST = 1'b0;
    out_l = 32'h00C38001;
    out_r = 32'h005A7FFE;
    // BCK running, no LRCK edge yet: both stay idle and drive 0
    repeat (3) bck_slot(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    half(32, {16'hA5C3, 16'h0000}, -1, 0);
    half(32, {16'h1234, 16'h0000}, -1, 0);
    half(12, {12'hABC, 20'h0}, -1, 1);
    half(32, {1'b0, 24'hC0FFEE, 7'h0}, -1, 0);
    half(32, $urandom, 6, 0);
    for (int r = 0; r < 36; r++) half(opts[$urandom_range(5, 0)], $urandom, -1, 2);
    half(32, $urandom, -1, 0);
    repeat (20) @(negedge iCLK);
    check("a_commits_outstanding", 32'(qa.size()), 32'd0);
    check("b_commits_outstanding", 32'(qb.size()), 32'd0);
    check("a_out_stb_count", 32'(stb_got[0]), 32'(stb_exp[0]));
    check("b_out_stb_count", 32'(stb_got[1]), 32'(stb_exp[1]));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
